// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG word generator.
package trng_pkg;

    // Von Neumann pair tracker: waiting for a first bit, or holding one.
    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } debias_state_e;

    // Run counter must be able to hold the value `limit` itself.
    function automatic int unsigned run_cnt_width(input int unsigned limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/trng_debias.sv
// Von Neumann debiaser: consumes bits in pairs, emits the first bit of an
// unequal pair (01 -> 0, 10 -> 1) and discards equal pairs.
module trng_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic in_valid,
    input  logic in_bit,
    output logic out_valid,
    output logic out_bit
);

    debias_state_e state_q, state_d;
    logic          first_q, first_d;

    // State and held first bit of the current pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Pair tracking; the output is same-cycle so the packer sees the pair result
    // on the edge that consumes the second bit.
    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        out_valid = 1'b0;
        out_bit   = first_q;
        if (clr) begin
            state_d = IDLE;
            first_d = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    first_d = in_bit;
                    state_d = HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    state_d   = IDLE;
                    out_valid = first_q ^ in_bit;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/trng_word_gen.sv
// TRNG word generator: synchronises oscillator channels, XOR-combines them,
// optionally debiases, packs bits into words over valid/ready, and blocks
// output when the combined stream repeats too long.
module trng_word_gen
    import trng_pkg::*;
#(
    parameter int unsigned NUM_OSCILLATORS = 3,
    parameter int unsigned NUM_INVERTER    = 3,
    parameter int unsigned WORD_WIDTH      = 8,
    parameter int unsigned DEBIAS          = 1,
    parameter int unsigned REP_LIMIT       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trng_en,
    input  logic [NUM_OSCILLATORS-1:0] raw_bits,
    output logic [WORD_WIDTH-1:0]      word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       health_fail
);

    localparam int unsigned RUN_W  = run_cnt_width(REP_LIMIT);
    localparam int unsigned FILL_W = $clog2(WORD_WIDTH);
    localparam int unsigned AGE_W  = 2;

    // Inverter count only shapes the oscillator bank; nothing to build here.
    if (NUM_INVERTER == 0) begin : g_no_inverters
    end

    logic [NUM_OSCILLATORS-1:0] sync1_q, sync1_d;
    logic [NUM_OSCILLATORS-1:0] sync2_q, sync2_d;
    logic [AGE_W-1:0]           en_age_q, en_age_d;
    logic [RUN_W-1:0]           run_cnt_q, run_cnt_d;
    logic                       last_c_q, last_c_d;
    logic                       health_fail_q, health_fail_d;
    logic [FILL_W-1:0]          fill_q, fill_d;
    logic [WORD_WIDTH-1:0]      word_data_q, word_data_d;
    logic                       word_valid_q, word_valid_d;

    logic c_bit_c;
    logic c_valid_c;
    logic feed_valid_c;
    logic emit_valid_c;
    logic emit_bit_c;

    // Two-flop synchronisers and enable-age counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            en_age_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            en_age_q <= en_age_d;
        end
    end

    // Combined bit is trusted only once enable has been high for two edges,
    // which is how long the synchroniser takes to flush stale samples.
    always_comb begin
        sync1_d   = raw_bits;
        sync2_d   = sync1_q;
        en_age_d  = '0;
        if (trng_en) begin
            en_age_d = (en_age_q == AGE_W'(2)) ? en_age_q : en_age_q + AGE_W'(1);
        end
        c_bit_c   = ^sync2_q;
        c_valid_c = trng_en & (en_age_q == AGE_W'(2));
    end

    // Repetition-count health test state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q     <= '0;
            last_c_q      <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            last_c_q      <= last_c_d;
            health_fail_q <= health_fail_d;
        end
    end

    // Run length of equal combined bits; a zero count marks "no previous bit".
    always_comb begin
        run_cnt_d     = run_cnt_q;
        last_c_d      = last_c_q;
        health_fail_d = health_fail_q;
        if (!trng_en) begin
            run_cnt_d     = '0;
            health_fail_d = 1'b0;
        end else if (c_valid_c) begin
            if ((run_cnt_q == '0) || (c_bit_c != last_c_q)) begin
                run_cnt_d = RUN_W'(1);
            end else if (run_cnt_q != RUN_W'(REP_LIMIT)) begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
            end
            last_c_d = c_bit_c;
            if (run_cnt_d == RUN_W'(REP_LIMIT)) begin
                health_fail_d = 1'b1;
            end
        end
    end

    assign feed_valid_c = c_valid_c & ~health_fail_q;

    // Optional von Neumann stage between the combiner and the packer.
    if (DEBIAS != 0) begin : g_debias
        trng_debias u_debias (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (~trng_en),
            .in_valid (feed_valid_c),
            .in_bit   (c_bit_c),
            .out_valid(emit_valid_c),
            .out_bit  (emit_bit_c)
        );
    end else begin : g_passthru
        assign emit_valid_c = feed_valid_c;
        assign emit_bit_c   = c_bit_c;
    end

    // Word packer and output handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q       <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
        end
    end

    // Bits land LSB first; while a word is pending (including its handshake
    // cycle) new bits are dropped so the presented word never changes.
    always_comb begin
        fill_d       = fill_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end
        if (!trng_en) begin
            fill_d = '0;
        end else if (emit_valid_c && !word_valid_q) begin
            word_data_d[fill_q] = emit_bit_c;
            if (fill_q == FILL_W'(WORD_WIDTH - 1)) begin
                fill_d       = '0;
                word_valid_d = 1'b1;
            end else begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    assign word_data   = word_data_q;
    assign word_valid  = word_valid_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_word_gen.sv
// Bench for trng_word_gen: a DEBIAS=0 and a DEBIAS=1 instance share stimulus
// and are compared every cycle against a bit-stream reference model.
module tb_trng_word_gen;

    localparam int unsigned NOSC = 3;
    localparam int unsigned WW   = 8;
    localparam int unsigned RL   = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            trng_en;
    logic [NOSC-1:0] raw_bits;
    logic            word_ready;
    logic [WW-1:0]   wd0, wd1;
    logic            wv0, wv1, hf0, hf1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    trng_word_gen #(.NUM_OSCILLATORS(NOSC), .NUM_INVERTER(3), .WORD_WIDTH(WW),
                    .DEBIAS(0), .REP_LIMIT(RL)) dut0 (
        .clk(clk), .rst_n(rst_n), .trng_en(trng_en), .raw_bits(raw_bits),
        .word_data(wd0), .word_valid(wv0), .word_ready(word_ready), .health_fail(hf0)
    );

    trng_word_gen #(.NUM_OSCILLATORS(NOSC), .NUM_INVERTER(3), .WORD_WIDTH(WW),
                    .DEBIAS(1), .REP_LIMIT(RL)) dut1 (
        .clk(clk), .rst_n(rst_n), .trng_en(trng_en), .raw_bits(raw_bits),
        .word_data(wd1), .word_valid(wv1), .word_ready(word_ready), .health_fail(hf1)
    );

    // Reference model; index 0 = no debias, index 1 = von Neumann.
    int            age;
    bit            p1, p2;
    bit            m_hf [2];
    bit            m_first [2];
    bit            m_valid [2];
    bit            m_last [2];
    bit            m_fail [2];
    int            m_fill [2];
    int            m_run [2];
    logic [WW-1:0] m_data [2];

    task automatic model_reset();
        age = 0; p1 = 0; p2 = 0;
        for (int m = 0; m < 2; m++) begin
            m_hf[m] = 0; m_first[m] = 0; m_valid[m] = 0; m_last[m] = 0;
            m_fail[m] = 0; m_fill[m] = 0; m_run[m] = 0; m_data[m] = '0;
        end
    endtask

    // One clock edge of the behaviour: combined bit is the parity of the raw
    // inputs two edges back, usable once enable is two edges old.
    task automatic model_edge(input bit en, input logic [NOSC-1:0] raw, input bit rdy);
        bit cv, c, fail_pre, valid_pre, emit, b;
        cv = en && (age >= 2);
        c  = p2;
        p2 = p1;
        p1 = ^raw;
        age = en ? ((age < 2) ? age + 1 : 2) : 0;
        for (int m = 0; m < 2; m++) begin
            fail_pre  = m_fail[m];
            valid_pre = m_valid[m];
            emit = 0; b = 0;
            if (!en) begin
                m_hf[m] = 0; m_fill[m] = 0; m_run[m] = 0; m_fail[m] = 0;
            end else if (cv) begin
                if (m_run[m] == 0 || c != m_last[m]) m_run[m] = 1;
                else if (m_run[m] < int'(RL)) m_run[m] = m_run[m] + 1;
                m_last[m] = c;
                if (m_run[m] == int'(RL)) m_fail[m] = 1;
                if (!fail_pre) begin
                    if (m == 0) begin
                        emit = 1; b = c;
                    end else if (!m_hf[m]) begin
                        m_hf[m] = 1; m_first[m] = c;
                    end else begin
                        m_hf[m] = 0;
                        if (m_first[m] != c) begin emit = 1; b = m_first[m]; end
                    end
                end
                if (emit && !valid_pre) begin
                    m_data[m][m_fill[m]] = b;
                    m_fill[m] = m_fill[m] + 1;
                    if (m_fill[m] == int'(WW)) begin
                        m_fill[m]  = 0;
                        m_valid[m] = 1;
                    end
                end
            end
            if (valid_pre && rdy) m_valid[m] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ":valid0"}, 32'(wv0), 32'(m_valid[0]));
        check({ph, ":hfail0"}, 32'(hf0), 32'(m_fail[0]));
        if (m_valid[0]) check({ph, ":data0"}, 32'(wd0), 32'(m_data[0]));
        check({ph, ":valid1"}, 32'(wv1), 32'(m_valid[1]));
        check({ph, ":hfail1"}, 32'(hf1), 32'(m_fail[1]));
        if (m_valid[1]) check({ph, ":data1"}, 32'(wd1), 32'(m_data[1]));
    endtask

    // Drive inputs between edges, take one edge, update model, compare.
    task automatic step(input string ph, input bit en, input logic [NOSC-1:0] raw, input bit rdy);
        trng_en = en; raw_bits = raw; word_ready = rdy;
        @(posedge clk);
        model_edge(en, raw, rdy);
        #1;
        compare_all(ph);
    endtask

    // Raw patterns whose parity is 1 or 0, drawn from the three-channel set.
    function automatic logic [NOSC-1:0] raw_for(input bit parity);
        logic [NOSC-1:0] r;
        r = parity ? 3'b001 : 3'b011;
        return r;
    endfunction

    initial begin
        int n_words1;
        bit held;
        rst_n = 1'b0; trng_en = 1'b0; raw_bits = '0; word_ready = 1'b0;
        model_reset();
        #12;
        check("reset:valid0", 32'(wv0), 32'(0));
        check("reset:data0",  32'(wd0), 32'(0));
        check("reset:hfail0", 32'(hf0), 32'(0));
        check("reset:valid1", 32'(wv1), 32'(0));
        check("reset:data1",  32'(wd1), 32'(0));
        check("reset:hfail1", 32'(hf1), 32'(0));
        #1 rst_n = 1'b1;

        // 1: combined stream 0,1,1,0,... -> debiased words 0xAA, one-cycle valid
        for (int i = 0; i < 3; i++) step("t1_idle", 0, 3'b000, 1);
        n_words1 = 0;
        for (int k = 0; k < 40; k++) begin
            step("t1", 1, raw_for((k % 4 == 1) || (k % 4 == 2)), 1);
            if (wv1) begin
                n_words1++;
                check("t1_word_aa", 32'(wd1), 32'h0000_00AA);
            end
        end
        check("t1_word_count", 32'(n_words1), 32'(2));

        // 2: stuck stream trips the health test on the 16th valid cycle
        step("t2_off", 0, 3'b001, 1);
        for (int j = 1; j <= 20; j++) begin
            step("t2", 1, 3'b001, 1);
            check("t2_hf_edge", 32'(hf1), 32'(j >= int'(2 + RL)));
            check("t2_no_word", 32'(wv1), 32'(0));
        end
        step("t2_clear", 0, 3'b001, 1);
        check("t2_hf_cleared", 32'(hf1), 32'(0));

        // 3: backpressure holds the word, one-cycle ready releases it
        held = 0;
        for (int i = 0; i < 20 && !m_valid[0]; i++) begin
            held = ~held;
            step("t3_fill", 1, raw_for(held), 0);
        end
        check("t3_word_up", 32'(wv0), 32'(1));
        for (int i = 0; i < 10; i++) begin
            held = ~held;
            step("t3_hold", 1, raw_for(held), 0);
            check("t3_still_valid", 32'(wv0), 32'(1));
        end
        step("t3_accept", 1, raw_for(~held), 1);
        check("t3_released", 32'(wv0), 32'(0));
        for (int i = 0; i < 12; i++) step("t3_next", 1, NOSC'($urandom), 0);
        step("t3_drain", 1, NOSC'($urandom), 1);

        // 4: enable dropped after five packed bits, then re-raised
        step("t4_off", 0, 3'b000, 1);
        for (int i = 0; i < 20 && m_fill[0] != 5; i++) step("t4_fill", 1, NOSC'($urandom), 1);
        check("t4_fill5", 32'(m_fill[0]), 32'(5));
        for (int i = 0; i < 3; i++) step("t4_drop", 0, NOSC'($urandom), 1);
        for (int i = 0; i < 24; i++) step("t4_re", 1, NOSC'($urandom), 1);

        // 5: asynchronous reset between edges with a word pending and health set
        step("t5_off", 0, 3'b000, 0);
        for (int i = 0; i < 22; i++) step("t5_load", 1, 3'b001, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async:valid0", 32'(wv0), 32'(0));
        check("t5_async:data0",  32'(wd0), 32'(0));
        check("t5_async:hfail0", 32'(hf0), 32'(0));
        check("t5_async:valid1", 32'(wv1), 32'(0));
        check("t5_async:data1",  32'(wd1), 32'(0));
        check("t5_async:hfail1", 32'(hf1), 32'(0));
        model_reset();
        #2 rst_n = 1'b1;

        // 6: pending word survives enable going low until accepted
        for (int i = 0; i < 20 && !m_valid[0]; i++) step("t6_fill", 1, NOSC'($urandom), 0);
        check("t6_word_up", 32'(wv0), 32'(1));
        for (int i = 0; i < 5; i++) begin
            step("t6_off", 0, NOSC'($urandom), 0);
            check("t6_pending", 32'(wv0), 32'(1));
            check("t6_no_fail", 32'(hf0), 32'(0));
        end
        step("t6_accept", 0, NOSC'($urandom), 1);
        check("t6_released", 32'(wv0), 32'(0));

        // Randomised soak
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 19) != 0), NOSC'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
